// File: rtl/rd_req_issuer.sv
// Source-data read initiator: pops job descriptors, splits each job into page-safe,
// MAX_BEATS-bounded bursts on a valid/ready read-address channel and tags every accepted burst.
module rd_req_issuer #(
  parameter int BEAT_BYTES = 64,
  parameter int MAX_BEATS  = 64,
  parameter int PAGE_BYTES = 4096
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        job_valid,
  output logic        job_rd,
  input  logic [63:0] job_src_addr,
  input  logic [25:0] job_rd_length,
  input  logic [15:0] job_id,
  output logic        ar_valid,
  input  logic        ar_ready,
  output logic [63:0] ar_addr,
  output logic [7:0]  ar_len,
  output logic        tag_wr,
  output logic [15:0] tag_job_id,
  input  logic        tag_almost_full,
  output logic        job_done,
  output logic        busy
);

  localparam int          BEAT_SH   = $clog2(BEAT_BYTES);
  localparam logic [63:0] BEAT_MASK = 64'(BEAT_BYTES - 1);
  localparam logic [63:0] PAGE_MASK = 64'(PAGE_BYTES - 1);

  typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] cur_addr;
  logic [21:0] beats_left;
  logic [15:0] cur_id;
  logic [8:0]  n_q;
  logic [27:0] beat_sum;
  logic [63:0] to_page;
  logic [8:0]  n_calc;
  logic        accept;
  logic        last_burst;

  // Burst size is the tightest of: beats remaining, burst cap, beats to page end.
  function automatic logic [8:0] burst_beats(input logic [21:0] left, input logic [63:0] room);
    logic [63:0] n;
    n = 64'(left);
    if (n > 64'(MAX_BEATS)) n = 64'(MAX_BEATS);
    if (room < n) n = room;
    return 9'(n);
  endfunction

  assign beat_sum   = 28'(job_src_addr & BEAT_MASK) + 28'(job_rd_length) + 28'(BEAT_BYTES - 1);
  assign to_page    = (64'(PAGE_BYTES) - (cur_addr & PAGE_MASK)) >> BEAT_SH;
  assign n_calc     = burst_beats(beats_left, to_page);
  assign accept     = ar_valid && ar_ready;
  assign last_burst = (beats_left == 22'(n_q));
  assign tag_wr     = accept;
  assign tag_job_id = cur_id;

  always_ff @(posedge clk) begin
    if (srst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    job_rd    = 1'b0;
    ar_valid  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy   = 1'b0;
        job_rd = job_valid && !srst;
        if (job_valid) state_nxt = (job_rd_length == '0) ? IDLE : CALC;
      end
      CALC: begin
        if (!tag_almost_full) state_nxt = ISSUE;
      end
      ISSUE: begin
        ar_valid = 1'b1;
        if (ar_valid && ar_ready) state_nxt = last_burst ? IDLE : CALC;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Externally visible registers come out of reset at zero.
  always_ff @(posedge clk) begin
    if (srst) begin
      cur_id   <= '0;
      ar_addr  <= '0;
      ar_len   <= '0;
      job_done <= 1'b0;
    end else begin
      job_done <= 1'b0;
      case (state)
        IDLE: if (job_valid) begin
          cur_id   <= job_id;
          job_done <= (job_rd_length == '0);
        end
        CALC: begin
          ar_addr <= cur_addr;
          ar_len  <= 8'(n_calc - 9'd1);
        end
        ISSUE: if (accept) job_done <= last_burst;
        default: ;
      endcase
    end
  end

  // Working address/beat counters; only meaningful once a job has been captured.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (job_valid) begin
        cur_addr   <= job_src_addr & ~BEAT_MASK;
        beats_left <= 22'(beat_sum >> BEAT_SH);
      end
      CALC: n_q <= n_calc;
      ISSUE: if (accept) begin
        cur_addr   <= cur_addr + (64'(n_q) << BEAT_SH);
        beats_left <= beats_left - 22'(n_q);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rd_req_issuer.sv
// Bench for rd_req_issuer: a burst-list model derived from byte ranges checks every cycle,
// directed scenarios pin latencies, stalls, backpressure, zero-length jobs and reset.
module tb_rd_req_issuer;

  localparam longint unsigned BEAT = 64;
  localparam longint unsigned MAXB = 64;
  localparam longint unsigned PAGE = 4096;

  logic        clk = 1'b0;
  logic        srst;
  logic        job_valid;
  logic        job_rd;
  logic [63:0] job_src_addr;
  logic [25:0] job_rd_length;
  logic [15:0] job_id;
  logic        ar_valid;
  logic        ar_ready;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic        tag_wr;
  logic [15:0] tag_job_id;
  logic        tag_almost_full;
  logic        job_done;
  logic        busy;

  rd_req_issuer #(.BEAT_BYTES(64), .MAX_BEATS(64), .PAGE_BYTES(4096)) dut (
    .clk(clk), .srst(srst), .job_valid(job_valid), .job_rd(job_rd),
    .job_src_addr(job_src_addr), .job_rd_length(job_rd_length), .job_id(job_id),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
    .tag_wr(tag_wr), .tag_job_id(tag_job_id), .tag_almost_full(tag_almost_full),
    .job_done(job_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [15:0] id;
    logic        last;
  } burst_t;

  burst_t      exp_q[$];
  logic        exp_done = 1'b0;
  logic [63:0] log_addr[16];
  logic [7:0]  log_len[16];
  logic [15:0] log_id[16];
  int          log_n = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Walk the byte range [start, end) cutting at page boundaries and at the burst cap.
  function automatic void model_job(input longint unsigned a, input longint unsigned l,
                                    input logic [15:0] id);
    longint unsigned cur, stop, lim, pg;
    burst_t b;
    cur  = a & ~(BEAT - 1);
    stop = ((a + l + BEAT - 1) / BEAT) * BEAT;
    while (cur < stop) begin
      pg  = (cur / PAGE + 1) * PAGE;
      lim = cur + MAXB * BEAT;
      if (pg < lim) lim = pg;
      if (stop < lim) lim = stop;
      b.addr = cur;
      b.len  = 8'((lim - cur) / BEAT - 1);
      b.id   = id;
      b.last = (lim == stop);
      exp_q.push_back(b);
      cur = lim;
    end
  endfunction

  always @(negedge clk) begin
    logic next_done;
    if (srst) begin
      exp_q.delete();
      exp_done = 1'b0;
    end else begin
      next_done = 1'b0;
      chk("job_done", {63'd0, job_done}, {63'd0, exp_done});
      chk("tag_wr", {63'd0, tag_wr}, {63'd0, ar_valid & ar_ready});
      if (job_rd) begin
        chk("job_rd_valid", {63'd0, job_valid}, 64'd1);
        chk("job_rd_idle", {63'd0, busy}, 64'd0);
        if (job_rd_length == 0) next_done = 1'b1;
        else model_job(job_src_addr, longint'(job_rd_length), job_id);
      end
      if (ar_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_req", {63'd0, ar_valid}, 64'd0);
        end else begin
          chk("ar_addr", ar_addr, exp_q[0].addr);
          chk("ar_len", {56'd0, ar_len}, {56'd0, exp_q[0].len});
          if (ar_ready) begin
            chk("tag_job_id", {48'd0, tag_job_id}, {48'd0, exp_q[0].id});
            if (log_n < 16) begin
              log_addr[log_n] = ar_addr;
              log_len[log_n]  = ar_len;
              log_id[log_n]   = tag_job_id;
              log_n++;
            end
            if (exp_q[0].last) next_done = 1'b1;
            void'(exp_q.pop_front());
          end
        end
      end
      exp_done = next_done;
    end
  end

  task automatic present_and_pop(input logic [63:0] a, input logic [25:0] l, input logic [15:0] id);
    int n;
    @(posedge clk); #1;
    job_valid = 1'b1; job_src_addr = a; job_rd_length = l; job_id = id;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!job_rd && n < 50);
    if (!job_rd) chk("pop_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (job_done !== 1'b1 && n < 3000);
    if (job_done !== 1'b1) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1'b1; job_valid = 1'b1; job_src_addr = 64'h1000; job_rd_length = 26'h40;
    job_id = 16'h55; ar_ready = 1'b1; tag_almost_full = 1'b0;

    // reset: no pop while srst even with a descriptor waiting
    repeat (3) begin
      @(negedge clk);
      chk("rst_job_rd", {63'd0, job_rd}, 64'd0);
    end
    chk("rst_ar_valid", {63'd0, ar_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_job_done", {63'd0, job_done}, 64'd0);
    chk("rst_tag_wr", {63'd0, tag_wr}, 64'd0);
    chk("rst_ar_addr", ar_addr, 64'd0);
    chk("rst_ar_len", {56'd0, ar_len}, 64'd0);
    chk("rst_tag_id", {48'd0, tag_job_id}, 64'd0);
    @(posedge clk); #1;
    job_valid = 1'b0; srst = 1'b0;
    @(negedge clk);
    chk("idle_job_rd", {63'd0, job_rd}, 64'd0);

    // single beat: pop -> CALC -> ISSUE, accepted immediately
    log_n = 0;
    present_and_pop(64'h1010, 26'h30, 16'h00A1);
    @(negedge clk);
    chk("t1_calc_no_valid", {63'd0, ar_valid}, 64'd0);
    chk("t1_calc_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("t1_valid", {63'd0, ar_valid}, 64'd1);
    chk("t1_addr", ar_addr, 64'h1000);
    chk("t1_len", {56'd0, ar_len}, 64'd0);
    chk("t1_tag_wr", {63'd0, tag_wr}, 64'd1);
    chk("t1_tag_id", {48'd0, tag_job_id}, 64'h00A1);
    @(negedge clk);
    chk("t1_done", {63'd0, job_done}, 64'd1);
    chk("t1_idle", {63'd0, busy}, 64'd0);

    // unaligned tail
    log_n = 0;
    present_and_pop(64'h1030, 26'h20, 16'h00B2);
    wait_done();
    chk("t2_nburst", 64'(log_n), 64'd1);
    chk("t2_addr", log_addr[0], 64'h1000);
    chk("t2_len", {56'd0, log_len[0]}, 64'd1);

    // page split
    log_n = 0;
    present_and_pop(64'h0FC0, 26'h100, 16'h00C3);
    wait_done();
    chk("t3_nburst", 64'(log_n), 64'd2);
    chk("t3_addr0", log_addr[0], 64'h0FC0);
    chk("t3_len0", {56'd0, log_len[0]}, 64'd0);
    chk("t3_addr1", log_addr[1], 64'h1000);
    chk("t3_len1", {56'd0, log_len[1]}, 64'd2);
    chk("t3_id1", {48'd0, log_id[1]}, 64'h00C3);

    // max-burst split with the first burst stalled for 5 cycles
    log_n = 0;
    ar_ready = 1'b0;
    present_and_pop(64'h0, 26'h2000, 16'h00D4);
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_valid", {63'd0, ar_valid}, 64'd1);
      chk("t4_hold_addr", ar_addr, 64'h0);
      chk("t4_hold_len", {56'd0, ar_len}, 64'd63);
      chk("t4_no_tag", {63'd0, tag_wr}, 64'd0);
    end
    @(posedge clk); #1;
    ar_ready = 1'b1;
    wait_done();
    chk("t4_nburst", 64'(log_n), 64'd2);
    chk("t4_addr1", log_addr[1], 64'h1000);
    chk("t4_len1", {56'd0, log_len[1]}, 64'd63);

    // tag FIFO backpressure holds the FSM in CALC
    log_n = 0;
    tag_almost_full = 1'b1;
    present_and_pop(64'h2000, 26'h40, 16'h00E5);
    repeat (4) begin
      @(negedge clk);
      chk("t5_blocked", {63'd0, ar_valid}, 64'd0);
      chk("t5_busy", {63'd0, busy}, 64'd1);
    end
    @(posedge clk); #1;
    tag_almost_full = 1'b0;
    @(negedge clk);
    chk("t5_release_calc", {63'd0, ar_valid}, 64'd0);
    @(negedge clk);
    chk("t5_release_valid", {63'd0, ar_valid}, 64'd1);
    chk("t5_addr", ar_addr, 64'h2000);
    wait_done();

    // zero-length job then a normal job back-to-back; reset during its ISSUE
    log_n = 0;
    ar_ready = 1'b0;
    @(posedge clk); #1;
    job_valid = 1'b1; job_src_addr = 64'h5000; job_rd_length = 26'h0; job_id = 16'h000F;
    @(negedge clk);
    chk("t6_pop0", {63'd0, job_rd}, 64'd1);
    @(posedge clk); #1;
    job_src_addr = 64'h3000; job_rd_length = 26'h80; job_id = 16'h0066;
    @(negedge clk);
    chk("t6_zero_done", {63'd0, job_done}, 64'd1);
    chk("t6_pop1", {63'd0, job_rd}, 64'd1);
    chk("t6_zero_noreq", {63'd0, ar_valid}, 64'd0);
    @(posedge clk); #1;
    job_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_issue", {63'd0, ar_valid}, 64'd1);
    @(posedge clk); #1;
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", {63'd0, ar_valid}, 64'd0);
    chk("t6_rst_busy", {63'd0, busy}, 64'd0);
    chk("t6_rst_done", {63'd0, job_done}, 64'd0);
    repeat (3) @(negedge clk);
    chk("t6_no_tags", 64'(log_n), 64'd0);
    ar_ready = 1'b1;

    // model-checked table of mixed jobs
    begin
      logic [63:0] ta[4];
      logic [25:0] tl[4];
      ta[0] = 64'h1FF8; tl[0] = 26'h1000;
      ta[1] = 64'h5040; tl[1] = 26'h3001;
      ta[2] = 64'h123;  tl[2] = 26'h1;
      ta[3] = 64'hFFC0; tl[3] = 26'h2041;
      for (int i = 0; i < 4; i++) begin
        log_n = 0;
        present_and_pop(ta[i], tl[i], 16'(16'h0070 + i));
        wait_done();
      end
      chk("tbl0_addr_last", log_addr[0], 64'hFFC0);
      chk("tbl0_len_first", {56'd0, log_len[0]}, 64'd0);
    end

    repeat (4) @(negedge clk);
    chk("end_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
